deser_rx: RTL and testbench

//  Serial-in/parallel-out receiver: the receiving end of the serial stream that shift_register produces.

---
 rtl/deser_pkg.sv | 20 ++
 rtl/deser_shift_stage.sv | 72 +++++++
 rtl/deser_rx.sv | 101 ++++++++++
 tb/tb_deser_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the deser_rx serial receiver.
// DESER_PARITY_EN adds one even-parity bit after each word's data bits.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    localparam string DIR_LEFT  = "left";
    localparam string DIR_RIGHT = "right";

`ifdef DESER_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

endpackage

// File: rtl/deser_shift_stage.sv
// Shift register, bit counter and parity accumulator for deser_rx.
// DESER_PARITY_EN: a frame ends with one parity bit that is compared, not shifted.
module deser_shift_stage
    import deser_pkg::*;
#(
    parameter int unsigned num_bits = 8,
    parameter string       dir      = DIR_LEFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sdi,
    input  logic                sen,
    output logic [num_bits-1:0] o_word,
    output logic                o_last_data,
    output logic                o_done,
    output logic                o_perr
);

    localparam int unsigned    CW        = $clog2(num_bits + 1);
    localparam logic [CW-1:0]  LAST_DATA = CW'(num_bits - 1);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(num_bits - 1 + PAR_BITS);
    localparam bit             LEFT      = (dir != DIR_RIGHT);

    logic [num_bits-1:0] r_sreg;
    logic [CW-1:0]       r_cnt;
    logic [num_bits-1:0] w_shifted;
    logic                w_data_bit;

    generate
        if (LEFT) begin : g_left
            assign w_shifted = {r_sreg[num_bits-2:0], sdi};
        end else begin : g_right
            assign w_shifted = {sdi, r_sreg[num_bits-1:1]};
        end
    endgenerate

    assign w_data_bit  = (r_cnt <= LAST_DATA);
    assign o_last_data = sen && (r_cnt == LAST_DATA);
    assign o_done      = sen && (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (sen) begin
            r_cnt <= o_done ? '0 : r_cnt + CW'(1);
            if (w_data_bit)
                r_sreg <= w_shifted;
        end else begin
            r_cnt <= '0;
        end
    end

`ifdef DESER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_par <= 1'b0;
        else if (sen && w_data_bit)
            r_par <= (r_cnt == '0) ? sdi : (r_par ^ sdi);
    end

    // The completing edge carries the parity bit, so the word is the register as it stands.
    assign o_word = r_sreg;
    assign o_perr = r_par ^ sdi;
`else
    assign o_word = w_shifted;
    assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/deser_rx.sv
// Serial-in/parallel-out receiver with a valid/ready output buffer and overrun/abort flags.
// DESER_PARITY_EN enables the PAR state and the perr qualifier on par_out.
module deser_rx
    import deser_pkg::*;
#(
    parameter int unsigned num_bits = 8,
    parameter string       dir      = DIR_LEFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sdi,
    input  logic                sen,
    input  logic                ready,
    input  logic                clr,
    output logic [num_bits-1:0] par_out,
    output logic                valid,
    output logic                ovf,
    output logic                abort,
    output logic                perr
);

    state_t              r_state, w_next;
    logic [num_bits-1:0] r_par_out;
    logic                r_valid, r_ovf, r_abort, r_perr;
    logic [num_bits-1:0] w_word;
    logic                w_last_data, w_done, w_perr, w_abort, w_load;

    deser_shift_stage #(
        .num_bits (num_bits),
        .dir      (dir)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .sdi         (sdi),
        .sen         (sen),
        .o_word      (w_word),
        .o_last_data (w_last_data),
        .o_done      (w_done),
        .o_perr      (w_perr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sen) w_next = SHIFT;
            SHIFT: begin
                if (!sen)
                    w_next = IDLE;
                else if (w_last_data)
                    w_next = (PAR_BITS != 0) ? PAR : IDLE;
            end
            PAR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_abort = (r_state != IDLE) && !sen;
    end

    // A completing word may replace the buffered one only if that one is leaving on this edge.
    assign w_load = !r_valid || ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_out <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ovf     <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_done && w_load) begin
                r_par_out <= w_word;
                r_valid   <= 1'b1;
                r_perr    <= w_perr;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
            end
            if (w_done && !w_load)
                r_ovf <= 1'b1;
            else if (clr)
                r_ovf <= 1'b0;
        end
    end

    assign par_out = r_par_out;
    assign valid   = r_valid;
    assign ovf     = r_ovf;
    assign abort   = r_abort;
    assign perr    = r_perr;

endmodule

// File: tb/tb_deser_rx.sv
// Directed bench for deser_rx (num_bits=8), left and right instances on a shared stream.
// DESER_PARITY_EN adds a parity bit to every frame and the perr cases.
module tb_deser_rx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sdi   = 1'b0;
    logic       sen   = 1'b0;
    logic       ready = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] l_par, r_par;
    logic       l_valid, l_ovf, l_abort, l_perr;
    logic       r_valid, r_ovf, r_abort, r_perr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    deser_rx #(.num_bits(8), .dir("left")) u_dut_l (
        .clk(clk), .reset(reset), .sdi(sdi), .sen(sen), .ready(ready), .clr(clr),
        .par_out(l_par), .valid(l_valid), .ovf(l_ovf), .abort(l_abort), .perr(l_perr)
    );

    deser_rx #(.num_bits(8), .dir("right")) u_dut_r (
        .clk(clk), .reset(reset), .sdi(sdi), .sen(sen), .ready(ready), .clr(clr),
        .par_out(r_par), .valid(r_valid), .ovf(r_ovf), .abort(r_abort), .perr(r_perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Drives one frame MSB first; optionally raises ready alongside the final bit.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic rl);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sen = 1'b1;
            sdi = d[i];
        end
`ifdef DESER_PARITY_EN
        @(negedge clk);
        sdi = pbit;
`else
        if (pbit === 1'bx) sdi = 1'b0;
`endif
        if (rl) ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        sen = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_par",   {24'd0, l_par}, 32'h00);
        check("rst_valid", {31'd0, l_valid}, 32'd0);
        check("rst_ovf",   {31'd0, l_ovf}, 32'd0);
        check("rst_abort", {31'd0, l_abort}, 32'd0);
        check("rst_perr",  {31'd0, l_perr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-word while a word is buffered
        send_frame(8'hA5, even_par(8'hA5), 1'b0);
        tick();
        check("t1_pre_par", {24'd0, l_par}, 32'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sen = 1'b1;
            sdi = 1'b1;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t1_rst_par",   {24'd0, l_par}, 32'h00);
        check("t1_rst_valid", {31'd0, l_valid}, 32'd0);
        check("t1_rst_abort", {31'd0, l_abort}, 32'd0);
        @(negedge clk);
        sen = 1'b0;
        sdi = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_frame(8'h5A, even_par(8'h5A), 1'b0);
        tick();
        check("t1_5a_par",   {24'd0, l_par}, 32'h5A);
        check("t1_5a_valid", {31'd0, l_valid}, 32'd1);
        @(negedge clk);
        sen   = 1'b0;
        ready = 1'b1;
        tick();
        check("t1_accept", {31'd0, l_valid}, 32'd0);

        // MSB-first vs LSB-first landing, ready held high
        send_frame(8'h01, even_par(8'h01), 1'b0);
        check("t2_valid_before", {31'd0, l_valid}, 32'd0);
        tick();
        check("t2_valid", {31'd0, l_valid}, 32'd1);
        check("t2_par_l", {24'd0, l_par}, 32'h01);
        check("t3_par_r", {24'd0, r_par}, 32'h80);
        go_idle();
        tick();
        check("t2_valid_drop", {31'd0, l_valid}, 32'd0);
        check("t2_idle_noabort", {31'd0, l_abort}, 32'd0);

        // Overrun, then accept, then clear
        ready = 1'b0;
        send_frame(8'h11, even_par(8'h11), 1'b0);
        send_frame(8'h22, even_par(8'h22), 1'b0);
        tick();
        check("t4_par",   {24'd0, l_par}, 32'h11);
        check("t4_valid", {31'd0, l_valid}, 32'd1);
        check("t4_ovf",   {31'd0, l_ovf}, 32'd1);
        @(negedge clk);
        sen   = 1'b0;
        ready = 1'b1;
        tick();
        check("t4_accept",   {31'd0, l_valid}, 32'd0);
        check("t4_ovf_held", {31'd0, l_ovf}, 32'd1);
        @(negedge clk);
        ready = 1'b0;
        clr   = 1'b1;
        tick();
        check("t4_clr", {31'd0, l_ovf}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Overrun and clr on the same edge: set wins
        send_frame(8'h33, even_par(8'h33), 1'b0);
        clr = 1'b1;
        send_frame(8'h44, even_par(8'h44), 1'b0);
        tick();
        check("t4_setwins_ovf", {31'd0, l_ovf}, 32'd1);
        check("t4_setwins_par", {24'd0, l_par}, 32'h33);
        go_idle();
        tick();
        check("t4_clr2", {31'd0, l_ovf}, 32'd0);
        clr = 1'b0;

        // Accept and completion on the same edge: new word loaded, no overrun
        send_frame(8'h55, even_par(8'h55), 1'b1);
        tick();
        check("t4_swap_par",   {24'd0, l_par}, 32'h55);
        check("t4_swap_valid", {31'd0, l_valid}, 32'd1);
        check("t4_swap_ovf",   {31'd0, l_ovf}, 32'd0);
        go_idle();
        tick();
        check("t4_swap_drain", {31'd0, l_valid}, 32'd0);

        // Abort after 5 bits with a word buffered
        ready = 1'b0;
        send_frame(8'h66, even_par(8'h66), 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sen = 1'b1;
            sdi = 1'b1;
        end
        go_idle();
        tick();
        check("t5_abort",     {31'd0, l_abort}, 32'd1);
        check("t5_valid",     {31'd0, l_valid}, 32'd1);
        check("t5_par",       {24'd0, l_par}, 32'h66);
        tick();
        check("t5_abort_end", {31'd0, l_abort}, 32'd0);
        @(negedge clk);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        send_frame(8'hC3, even_par(8'hC3), 1'b0);
        tick();
        check("t5_c3_par",   {24'd0, l_par}, 32'hC3);
        check("t5_c3_valid", {31'd0, l_valid}, 32'd1);
        check("t5_c3_ovf",   {31'd0, l_ovf}, 32'd0);
        @(negedge clk);
        sen   = 1'b0;
        ready = 1'b1;
        tick();

`ifdef DESER_PARITY_EN
        ready = 1'b0;
        send_frame(8'h07, 1'b0, 1'b0);
        tick();
        check("t6_valid", {31'd0, l_valid}, 32'd1);
        check("t6_par",   {24'd0, l_par}, 32'h07);
        check("t6_perr1", {31'd0, l_perr}, 32'd1);
        @(negedge clk);
        sen   = 1'b0;
        ready = 1'b1;
        tick();
        check("t6_perr_acc", {31'd0, l_perr}, 32'd0);
        @(negedge clk);
        ready = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        tick();
        check("t6_perr0", {31'd0, l_perr}, 32'd0);
        check("t6_valid2", {31'd0, l_valid}, 32'd1);
`else
        check("t6_perr_tied", {31'd0, l_perr}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
